// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq : registered ALU with post-shift and a multi-cycle shift-add MUL |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       cin,
  input  logic [3:0]                 op,
  input  logic [1:0]                 sh_mode,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           y,
  output logic                       flag_z,
  output logic                       flag_n,
  output logic                       flag_c,
  output logic                       flag_v
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [SW:0] STEP_LAST = (SW+1)'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [SW:0]      step_q, step_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] ma_q, ma_d, mb_q, mb_d;
  logic [1:0]       mmode_q, mmode_d;
  logic [SW-1:0]    mamt_q, mamt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic             out_valid_q, out_valid_d;

  logic             can_load, accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend, pre, alu_y, mul_y;
  logic             is_arith, is_sub, alu_c, alu_v;

  function automatic logic [WIDTH-1:0] do_shift(input logic [WIDTH-1:0] v,
                                                input logic [1:0] mode,
                                                input logic [SW-1:0] amt);
    logic [WIDTH-1:0] r;
    case (mode)
      2'b01:   r = v >> amt;
      2'b10:   r = v << amt;
      2'b11:   r = WIDTH'($signed(v) >>> amt);
      default: r = v;
    endcase
    return r;
  endfunction

  assign can_load = !out_valid_q || out_ready;
  assign in_ready = (state_q == IDLE) && can_load;
  assign accept   = in_valid && in_ready;

  // Subtract ops keep the borrow in bit WIDTH of the (WIDTH+1)-bit result.
  always_comb begin
    sum      = '0;
    addend   = b;
    is_arith = 1'b1;
    is_sub   = 1'b0;
    pre      = a;
    case (op)
      4'd1: sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      4'd2: begin sum = {1'b0, a} + {1'b0, ~b}; addend = ~b; end
      4'd3: begin sum = {1'b0, a} + {{WIDTH{1'b0}}, cin}; addend = '0; end
      4'd4: sum = {1'b0, a} + {1'b0, b};
      4'd5: begin sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin}; is_sub = 1'b1; end
      4'd6: begin sum = {1'b0, a} - {1'b0, b}; is_sub = 1'b1; end
      4'd7: begin sum = {1'b0, a} - {{WIDTH{1'b0}}, cin}; addend = '0; is_sub = 1'b1; end
      default: is_arith = 1'b0;
    endcase
    case (op)
      4'd8:  pre = a & b;
      4'd9:  pre = a | b;
      4'd10: pre = a ^ b;
      4'd11: pre = ~a;
      default: if (is_arith) pre = sum[WIDTH-1:0];
    endcase
    alu_c = is_arith && sum[WIDTH];
    alu_v = is_arith && ((a[WIDTH-1] ^ addend[WIDTH-1]) == is_sub)
                     && (sum[WIDTH-1] != a[WIDTH-1]);
    alu_y = do_shift(pre, sh_mode, shamt);
    mul_y = do_shift(acc_q, mmode_q, mamt_q);
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    mmode_d     = mmode_q;
    mamt_d      = mamt_q;
    y_d         = y_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        if (op == OP_MUL) begin
          ma_d    = a;
          mb_d    = b;
          mmode_d = sh_mode;
          mamt_d  = shamt;
          acc_d   = '0;
          step_d  = '0;
          state_d = MUL;
        end else begin
          y_d         = alu_y;
          z_d         = (alu_y == '0);
          n_d         = alu_y[WIDTH-1];
          c_d         = alu_c;
          v_d         = alu_v;
          out_valid_d = 1'b1;
        end
      end
    end else if (step_q != STEP_LAST) begin
      if (ma_q[step_q[SW-1:0]]) acc_d = acc_q + (mb_q << step_q);
      step_d = step_q + 1'b1;
    end else if (can_load) begin
      y_d         = mul_y;
      z_d         = (mul_y == '0);
      n_d         = mul_y[WIDTH-1];
      c_d         = 1'b0;
      v_d         = 1'b0;
      out_valid_d = 1'b1;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      acc_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      mmode_q     <= '0;
      mamt_q      <= '0;
      y_q         <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      mmode_q     <= mmode_d;
      mamt_q      <= mamt_d;
      y_q         <= y_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_seq : directed scoreboard bench for alu_seq (WIDTH = 8)            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, cin, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [3:0] op;
  logic [1:0] sh_mode;
  logic [2:0] shamt;
  logic       flag_z, flag_n, flag_c, flag_v;

  typedef struct packed {
    logic [7:0] y;
    logic       z, n, c, v;
  } res_t;

  res_t sb[$];
  int compared = 0;
  int mism     = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .sh_mode(sh_mode), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input logic [7:0] ey, input logic ez, en, ec, ev);
    sb.push_back(res_t'{ey, ez, en, ec, ev});
  endtask

  task automatic check_out(input string tag);
    res_t o, e;
    o = {y, flag_z, flag_n, flag_c, flag_v};
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(o), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(o), 32'(e));
    end
  endtask

  // One-cycle issue: inputs set on the falling edge, sampled 1ns after the accept edge.
  task automatic issue(input logic [7:0] ia, ib, input logic ic, input logic [3:0] iop,
                       input logic [1:0] ism, input logic [2:0] isa);
    @(negedge clk);
    a = ia; b = ib; cin = ic; op = iop; sh_mode = ism; shamt = isa;
    in_valid = 1'b1;
    #1 chk("in_ready_pre", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = '0; sh_mode = '0; shamt = '0;
    #1 chk("reset_state", 32'({out_valid, y, flag_z, flag_n, flag_c, flag_v}), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    issue(8'hFF, 8'h01, 1'b0, 4'd4, 2'b00, 3'd0); expect_res(8'h00, 1, 0, 1, 0); check_out("add_carry");
    issue(8'h7F, 8'h01, 1'b0, 4'd4, 2'b00, 3'd0); expect_res(8'h80, 0, 1, 0, 1); check_out("add_ovf");
    issue(8'h00, 8'h01, 1'b0, 4'd6, 2'b00, 3'd0); expect_res(8'hFF, 0, 1, 1, 0); check_out("sub_borrow");
    issue(8'h81, 8'h00, 1'b0, 4'd0, 2'b11, 3'd1); expect_res(8'hC0, 0, 1, 0, 0); check_out("asr");
    issue(8'h81, 8'h00, 1'b0, 4'd0, 2'b10, 3'd1); expect_res(8'h02, 0, 0, 0, 0); check_out("shl");
    issue(8'h10, 8'h05, 1'b1, 4'd5, 2'b00, 3'd0); expect_res(8'h0A, 0, 0, 0, 0); check_out("sbc");
    issue(8'h05, 8'h03, 1'b0, 4'd2, 2'b00, 3'd0); expect_res(8'h01, 0, 0, 1, 0); check_out("add_notb");
    issue(8'h0F, 8'h00, 1'b0, 4'd11, 2'b00, 3'd0); expect_res(8'hF0, 0, 1, 0, 0); check_out("not_a");
    issue(8'hF0, 8'hFF, 1'b0, 4'd10, 2'b01, 3'd4); expect_res(8'h00, 1, 0, 0, 0); check_out("xor_lsr");
    issue(8'h80, 8'h80, 1'b1, 4'd1, 2'b00, 3'd0); expect_res(8'h01, 0, 0, 1, 1); check_out("adc_ovf");
    issue(8'h80, 8'h00, 1'b1, 4'd7, 2'b00, 3'd0); expect_res(8'h7F, 0, 0, 0, 1); check_out("dec_ovf");
    issue(8'h80, 8'h00, 1'b0, 4'd3, 2'b00, 3'd0); expect_res(8'h80, 0, 1, 0, 0); check_out("inc_nocin");

    // Multiply 13*11: busy through the 8 steps, result on edge 9.
    issue(8'd13, 8'd11, 1'b0, 4'd12, 2'b00, 3'd0);
    expect_res(8'h8F, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
      chk("mul_busy_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("mul_edge8_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_out("mul_result");

    // Drain, then stall the consumer across two back-to-back logic ops.
    @(posedge clk); #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); out_ready = 1'b0;
    issue(8'hF0, 8'h3C, 1'b0, 4'd8, 2'b00, 3'd0); expect_res(8'h30, 0, 0, 0, 0); check_out("and_first");
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; op = 4'd9; in_valid = 1'b1;
    #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", 32'({out_valid, in_ready, y}), 32'({1'b1, 1'b0, 8'h30}));
    end
    @(negedge clk); out_ready = 1'b1;
    #1 chk("unstall_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    expect_res(8'hFF, 0, 1, 0, 0); check_out("or_second");

    // Reset mid-multiply: nothing may emerge afterwards.
    issue(8'd13, 8'd11, 1'b0, 4'd12, 2'b00, 3'd0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid_mul", 32'({out_valid, y}), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("aborted_mul_quiet", 32'(out_valid), 32'd0);
    end
    issue(8'h12, 8'h34, 1'b0, 4'd4, 2'b00, 3'd0); expect_res(8'h46, 0, 0, 0, 0); check_out("add_after_rst");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
`default_nettype wire
